cpu_register_bank: RTL and testbench
====================================

CPU_REGISTER_BANK -- requirements
Module: cpu_register_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter FPU, default 1, meaning 1 = 64 entries (x0-x31 then f0-f31) and 0 = 32 integer entries.
REQ-003 The block SHALL have parameter NUM_READ, default 3, meaning the number of read ports (legal range 1-4).
REQ-004 The block SHALL have parameter TAG_WIDTH, default 4, meaning the writeback tag width.
REQ-005 The block SHALL have parameter STACK_POINTER, default 32'h0001_0000, meaning the initial value of x2.
REQ-006 The block SHALL derive IDW = 5+FPU as the register-id width.
REQ-007 Ports SHALL be as follows:
- i_clock  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_stall  in  1  hold all read outputs.
- i_rs_id  in  NUM_READ*IDW  read ids; port k is at bits [k*IDW +: IDW].
- i_wb_tag  in  TAG_WIDTH  writeback tag.
- i_wb_rd  in  IDW  writeback destination id.
- i_wb_data  in  WIDTH  writeback data.
- o_rs  out  NUM_READ*WIDTH  read data; port k is at bits [k*WIDTH +: WIDTH].
- o_ready  out  1  clear sweep finished; bank usable.
- o_wb_tag  out  TAG_WIDTH  last accepted writeback tag.

Function
REQ-008 The block SHALL have FSM states CLEAR and READY, with reset state CLEAR.
REQ-009 In CLEAR, the block SHALL write one entry per cycle, indexed by sweep counter 0..NREG-1: value STACK_POINTER at index 2, 0 elsewhere.
REQ-010 The FSM SHALL move CLEAR->READY on the cycle after the write of index NREG-1, so o_ready rises exactly NREG cycles after reset deassertion.
REQ-011 READY SHALL be terminal; only i_reset returns the FSM to CLEAR.
REQ-012 In READY with i_stall=0, each port k SHALL register its result with 1-cycle latency.
REQ-013 The read result for port k SHALL be 0 if the id is 0; else i_wb_data if a write to that id is accepted in the same cycle (bypass); else the stored value.
REQ-014 Only integer id 0 SHALL be hardwired to zero; f0 (id 32) SHALL be an ordinary register.
REQ-015 With i_stall=1, o_rs SHALL hold its value, while writes SHALL still be accepted.
REQ-016 In CLEAR, o_rs SHALL be forced to 0.
REQ-017 A write SHALL be accepted when the FSM is READY and i_wb_tag != o_wb_tag.
REQ-018 On an accepted write, the block SHALL store i_wb_data to i_wb_rd, unless i_wb_rd = 0, in which case no store occurs.
REQ-019 On an accepted write, o_wb_tag SHALL take i_wb_tag, including when i_wb_rd = 0.
REQ-020 In CLEAR, the block SHALL accept no writes and SHALL leave o_wb_tag unchanged; the producer holds its tag until accepted.
REQ-021 A repeated tag SHALL cause no write; tag wrap-around is legal because only inequality is tested.
REQ-022 When multiple ports read the same id, the block SHALL return identical data on each.
REQ-023 The storage array SHALL have no reset term, so it may map to distributed RAM; the storage SHALL have NUM_READ read ports and 1 write port.

Reset
REQ-024 Asserting i_reset SHALL immediately set: FSM=CLEAR, sweep counter=0, o_ready=0, o_wb_tag=0, o_rs=0.
REQ-025 i_reset asserted mid-sweep or mid-operation SHALL restart the full sweep after deassertion; no partial state SHALL survive.
REQ-026 Deassertion SHALL be synchronous to i_clock.

Structure
REQ-027 The shared CPU types package SHALL hold REG_ID_SIZE, TAG_SIZE, the register ABI index constants (ZERO=0, SP=2, F0=32) and the FSM state enum.
REQ-028 A sub-module cpu_register_bypass SHALL implement one read port's zero/bypass/stored mux; the top instantiates it NUM_READ times via generate.

Verification
REQ-029 Reset release with FPU=1 -> o_ready=0 for 64 cycles and then 1; reads of x2 give 32'h0001_0000; reads of x5 and f3 give 0.
REQ-030 Write tag 1 to x7 with 32'hDEAD_BEEF, then read x7 -> 32'hDEAD_BEEF one cycle after the read id is presented; a repeat of tag 1 with x7=32'h1234 -> x7 unchanged.
REQ-031 Same-cycle write of tag 2 to x9 with 32'h5555_AAAA and read x9 on all 3 ports -> all ports show 32'h5555_AAAA next cycle (bypass).
REQ-032 Write x0=32'hFFFF_FFFF with tag 3 -> x0 reads 0 and o_wb_tag=3; write f0=32'h3F80_0000 with tag 4 -> f0 reads 32'h3F80_0000.
REQ-033 Tag 5 presented during CLEAR -> no store and o_wb_tag=0 until o_ready=1, then accepted on the first READY cycle.
REQ-034 i_stall held for 4 cycles while x7 is rewritten -> o_rs frozen at the old x7 value; after release -> new value appears.

Source files
------------

// File: rtl/cpu_register_bank_pkg.sv
// Shared CPU types: register-id and tag sizes, ABI register indices and the
// register bank state encoding.
package cpu_register_bank_pkg;

  localparam int REG_ID_SIZE = 6;   // x0-x31 plus f0-f31
  localparam int TAG_SIZE    = 4;

  // ABI register indices
  localparam int ZERO = 0;          // hardwired zero (integer file only)
  localparam int SP   = 2;          // stack pointer, preloaded by the sweep
  localparam int F0   = 32;         // first FP register, ordinary storage

  typedef enum logic {
    CLEAR = 1'b0,                   // init sweep in progress
    READY = 1'b1                    // bank usable, terminal until reset
  } bank_state_e;

endpackage

// File: rtl/cpu_register_bypass.sv
// One read port's result mux: x0 reads zero, a write accepted in the same
// cycle to the same id is forwarded, otherwise the stored value is used.
//   rs_id    : register id being read
//   wb_en    : a writeback is accepted this cycle
//   wb_rd    : writeback destination id
//   wb_data  : writeback data
//   stored   : storage array read for rs_id
//   rd_data  : selected read result (combinational)
module cpu_register_bypass
  import cpu_register_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDW   = 6
) (
  input  logic [IDW-1:0]   rs_id,
  input  logic             wb_en,
  input  logic [IDW-1:0]   wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [WIDTH-1:0] stored,
  output logic [WIDTH-1:0] rd_data
);

  // Only integer id 0 is forced; f0 (id 32) differs in the top id bit.
  always_comb begin
    if (rs_id == IDW'(ZERO))
      rd_data = '0;
    else if (wb_en && (wb_rd == rs_id))
      rd_data = wb_data;
    else
      rd_data = stored;
  end

endmodule

// File: rtl/cpu_register_bank.sv
// CPU register bank: NUM_READ registered read ports, one tagged writeback
// port. After reset a sweep writes every entry (x2 = STACK_POINTER, others
// zero), then the bank becomes READY and accepts writebacks whose tag
// differs from the last accepted tag.
//   i_clock, i_reset : clock, async active-high reset (released synchronously
//                      by the surrounding reset logic)
//   i_stall          : hold read outputs; writes still proceed
//   i_rs_id          : packed read ids, port k at [k*IDW +: IDW]
//   i_wb_tag/rd/data : writeback tag, destination, data
//   o_rs             : packed read data, port k at [k*WIDTH +: WIDTH]
//   o_ready          : sweep finished
//   o_wb_tag         : last accepted writeback tag
module cpu_register_bank
  import cpu_register_bank_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter int               FPU           = 1,
  parameter int               NUM_READ      = 3,
  parameter int               TAG_WIDTH     = TAG_SIZE,
  parameter logic [WIDTH-1:0] STACK_POINTER = WIDTH'(32'h0001_0000),
  localparam int              IDW           = 5 + FPU
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_stall,
  input  logic [NUM_READ*IDW-1:0]   i_rs_id,
  input  logic [TAG_WIDTH-1:0]      i_wb_tag,
  input  logic [IDW-1:0]            i_wb_rd,
  input  logic [WIDTH-1:0]          i_wb_data,
  output logic [NUM_READ*WIDTH-1:0] o_rs,
  output logic                      o_ready,
  output logic [TAG_WIDTH-1:0]      o_wb_tag
);

  localparam int NREG = 1 << IDW;

  bank_state_e state_q, state_d;
  logic [IDW-1:0] sweep_q;

  logic           wr_acc;
  logic           mem_we;
  logic [IDW-1:0] mem_wa;
  logic [WIDTH-1:0] mem_wd;

  logic [NUM_READ-1:0][IDW-1:0]   rs_id;
  logic [NUM_READ-1:0][WIDTH-1:0] rd_stored;
  logic [NUM_READ-1:0][WIDTH-1:0] rd_nxt;
  logic [NUM_READ-1:0][WIDTH-1:0] rs_q;

  // No reset term: contents are rebuilt by the sweep, which lets this map
  // onto distributed RAM (NUM_READ read ports, one write port).
  logic [WIDTH-1:0] mem [NREG];

  assign rs_id    = i_rs_id;
  assign o_rs     = rs_q;
  assign o_ready  = (state_q == READY);

  // ---------------------------------------------------------------------
  // State and sweep counter
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR)
        sweep_q <= sweep_q + 1'b1;
    end
  end

  // Single write port shared between the sweep and accepted writebacks.
  always_comb begin
    state_d = state_q;
    wr_acc  = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = i_wb_rd;
    mem_wd  = i_wb_data;
    if (state_q == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = sweep_q;
      mem_wd = (sweep_q == IDW'(SP)) ? STACK_POINTER : '0;
      if (sweep_q == IDW'(NREG - 1))
        state_d = READY;
    end else begin
      // Tags only need to differ, so wrap-around is harmless.
      wr_acc = (i_wb_tag != o_wb_tag);
      mem_we = wr_acc && (i_wb_rd != IDW'(ZERO));
    end
  end

  always_ff @(posedge i_clock) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  // ---------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    assign rd_stored[k] = mem[rs_id[k]];

    cpu_register_bypass #(
      .WIDTH (WIDTH),
      .IDW   (IDW)
    ) u_bypass (
      .rs_id   (rs_id[k]),
      .wb_en   (wr_acc),
      .wb_rd   (i_wb_rd),
      .wb_data (i_wb_data),
      .stored  (rd_stored[k]),
      .rd_data (rd_nxt[k])
    );
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      rs_q <= '0;
    else if (state_q == CLEAR)
      rs_q <= '0;
    else if (!i_stall)
      rs_q <= rd_nxt;
  end

  // Tag register advances on every accepted write, including to x0.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      o_wb_tag <= '0;
    else if (wr_acc)
      o_wb_tag <= i_wb_tag;
  end

endmodule

// File: tb/tb_cpu_register_bank.sv
// Scoreboard bench for cpu_register_bank: stimulus updates a behavioural
// model of the register file and queues the expected outputs for the next
// clock; a monitor pops and compares after every rising edge.
module tb_cpu_register_bank;

  localparam int WIDTH     = 32;
  localparam int FPU       = 1;
  localparam int NUM_READ  = 3;
  localparam int TAG_WIDTH = 4;
  localparam logic [WIDTH-1:0] SPV = 32'h0001_0000;
  localparam int IDW       = 5 + FPU;
  localparam int NREG      = 1 << IDW;

  logic                      i_clock = 1'b0;
  logic                      i_reset = 1'b1;
  logic                      i_stall = 1'b0;
  logic [NUM_READ*IDW-1:0]   i_rs_id = '0;
  logic [TAG_WIDTH-1:0]      i_wb_tag = '0;
  logic [IDW-1:0]            i_wb_rd = '0;
  logic [WIDTH-1:0]          i_wb_data = '0;
  logic [NUM_READ*WIDTH-1:0] o_rs;
  logic                      o_ready;
  logic [TAG_WIDTH-1:0]      o_wb_tag;

  cpu_register_bank #(
    .WIDTH(WIDTH), .FPU(FPU), .NUM_READ(NUM_READ),
    .TAG_WIDTH(TAG_WIDTH), .STACK_POINTER(SPV)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall),
    .i_rs_id(i_rs_id), .i_wb_tag(i_wb_tag), .i_wb_rd(i_wb_rd),
    .i_wb_data(i_wb_data), .o_rs(o_rs), .o_ready(o_ready),
    .o_wb_tag(o_wb_tag)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    logic [NUM_READ*WIDTH-1:0] rs;
    logic                      ready;
    logic [TAG_WIDTH-1:0]      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [WIDTH-1:0]     m_reg [NREG];
  logic [WIDTH-1:0]     m_rs  [NUM_READ];
  logic [TAG_WIDTH-1:0] m_tag;
  int                   sweep_left;

  task automatic check(input string name, input logic [NUM_READ*WIDTH-1:0] act,
                       input logic [NUM_READ*WIDTH-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_reg[i] = (i == 2) ? SPV : '0;
    for (int k = 0; k < NUM_READ; k++) m_rs[k] = '0;
    m_tag      = '0;
    sweep_left = NREG;
  endtask

  // Called at a falling edge; drives one cycle and returns at the next one.
  task automatic step(input bit stall, input logic [NUM_READ-1:0][IDW-1:0] ids,
                      input logic [TAG_WIDTH-1:0] tag, input logic [IDW-1:0] rd,
                      input logic [WIDTH-1:0] data);
    exp_t e;
    bit   acc;
    i_stall = stall; i_rs_id = ids; i_wb_tag = tag; i_wb_rd = rd; i_wb_data = data;
    acc = (sweep_left == 0) && (tag != m_tag);
    if (sweep_left > 0) begin
      for (int k = 0; k < NUM_READ; k++) m_rs[k] = '0;
    end else if (!stall) begin
      for (int k = 0; k < NUM_READ; k++) begin
        if (ids[k] == 0)                   m_rs[k] = '0;
        else if (acc && rd == ids[k])      m_rs[k] = data;
        else                               m_rs[k] = m_reg[ids[k]];
      end
    end
    if (acc) begin
      if (rd != 0) m_reg[rd] = data;
      m_tag = tag;
    end
    if (sweep_left > 0) sweep_left--;
    for (int k = 0; k < NUM_READ; k++) e.rs[k*WIDTH +: WIDTH] = m_rs[k];
    e.ready = (sweep_left == 0);
    e.tag   = m_tag;
    exp_q.push_back(e);
    @(negedge i_clock);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    #1;
    check("reset_ready", {95'd0, o_ready}, '0);
    check("reset_tag",   {92'd0, o_wb_tag}, '0);
    check("reset_rs",    o_rs, '0);
    model_reset();
    @(negedge i_clock);
    @(negedge i_clock);
    i_reset = 1'b0;
  endtask

  function automatic logic [NUM_READ-1:0][IDW-1:0] ids3(int a, int b, int c);
    logic [NUM_READ-1:0][IDW-1:0] r;
    r[0] = IDW'(a); r[1] = IDW'(b); r[2] = IDW'(c);
    return r;
  endfunction

  // Monitor
  always @(posedge i_clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rs",    o_rs, e.rs);
      check("ready", {95'd0, o_ready}, {95'd0, e.ready});
      check("tag",   {92'd0, o_wb_tag}, {92'd0, e.tag});
    end
  end

  initial begin
    logic [TAG_WIDTH-1:0] tag;
    logic [IDW-1:0]       rd;
    logic [NUM_READ-1:0][IDW-1:0] ids;
    int                   waitc;

    model_reset();
    @(negedge i_clock);
    @(negedge i_clock);
    do_reset();

    // Tag 5 offered during the sweep: must wait for READY, then land.
    for (int i = 0; i < NREG; i++) step(0, ids3(2, 5, 35), 4'd5, 6'd10, 32'hA5A5_0010);
    for (int i = 0; i < 3; i++)    step(0, ids3(2, 5, 35), 4'd5, 6'd10, 32'h0);
    step(0, ids3(10, 2, 35), 4'd5, 6'd10, 32'h0);

    // Write x7, read back, repeated tag must not write.
    step(0, ids3(0, 0, 0), 4'd1, 6'd7, 32'hDEAD_BEEF);
    step(0, ids3(7, 7, 2), 4'd1, 6'd7, 32'h0000_1234);
    step(0, ids3(7, 1, 2), 4'd1, 6'd7, 32'h0000_1234);

    // Same-cycle bypass on all ports.
    step(0, ids3(9, 9, 9), 4'd2, 6'd9, 32'h5555_AAAA);
    step(0, ids3(9, 9, 9), 4'd2, 6'd9, 32'h0);

    // x0 stays zero while the tag advances; f0 is ordinary storage.
    step(0, ids3(0, 0, 0), 4'd3, 6'd0, 32'hFFFF_FFFF);
    step(0, ids3(0, 32, 9), 4'd4, 6'd32, 32'h3F80_0000);
    step(0, ids3(32, 0, 32), 4'd4, 6'd32, 32'h0);

    // Stall freezes reads while x7 is rewritten.
    step(0, ids3(7, 7, 7), 4'd4, 6'd7, 32'h0);
    step(1, ids3(7, 7, 7), 4'd6, 6'd7, 32'h0BAD_F00D);
    for (int i = 0; i < 3; i++) step(1, ids3(7, 7, 7), 4'd6, 6'd7, 32'h0);
    step(0, ids3(7, 7, 7), 4'd6, 6'd7, 32'h0);

    // Reset mid-sweep restarts from scratch.
    do_reset();
    for (int i = 0; i < 20; i++) step(0, ids3(7, 2, 9), 4'd7, 6'd7, 32'h1);
    do_reset();
    for (int i = 0; i < NREG + 2; i++) step(0, ids3(7, 2, 9), 4'd0, 6'd7, 32'h1);

    // Randomized traffic with occasional resets.
    tag = '0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 799) == 0) do_reset();
      if ($urandom_range(0, 1) == 0) tag = TAG_WIDTH'($urandom);
      rd = ($urandom_range(0, 7) == 0) ? '0 : IDW'($urandom_range(0, NREG - 1));
      for (int k = 0; k < NUM_READ; k++)
        ids[k] = ($urandom_range(0, 3) == 0) ? rd : IDW'($urandom_range(0, NREG - 1));
      step($urandom_range(0, 4) == 0, ids, tag, rd, $urandom);
    end

    waitc = 0;
    while (exp_q.size() > 0 && waitc < 10) begin
      @(negedge i_clock);
      waitc++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
